universal_shift_engine: RTL and testbench

UNIVERSAL_SHIFT_ENGINE -- requirements
Module: universal_shift_engine

---
 rtl/use_pkg.sv | 46 ++++
 rtl/use_if.sv | 27 ++
 rtl/use_step.sv | 49 ++++
 rtl/universal_shift_engine.sv | 80 ++++++++
 tb/tb_universal_shift_engine.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/use_pkg.sv
// Shared types for the universal shift engine: opcodes, FSM states, step-op classification.
// Rotate opcodes are recognised only when USE_ROTATE_EN is defined.
package use_pkg;

    localparam logic [2:0] OPC_HOLD = 3'b000;
    localparam logic [2:0] OPC_SHR  = 3'b001;
    localparam logic [2:0] OPC_SHL  = 3'b010;
    localparam logic [2:0] OPC_LOAD = 3'b011;
    localparam logic [2:0] OPC_ASR  = 3'b100;
    localparam logic [2:0] OPC_ROR  = 3'b101;
    localparam logic [2:0] OPC_ROL  = 3'b110;
    localparam logic [2:0] OPC_RSVD = 3'b111;

    typedef enum logic [2:0] {
        OP_HOLD = OPC_HOLD,
        OP_SHR  = OPC_SHR,
        OP_SHL  = OPC_SHL,
        OP_LOAD = OPC_LOAD,
        OP_ASR  = OPC_ASR,
        OP_ROR  = OPC_ROR,
        OP_ROL  = OPC_ROL,
        OP_RSVD = OPC_RSVD
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Ops that walk through RUN one bit per edge; everything else finishes in IDLE.
    function automatic logic is_step_op(input op_e op);
        logic result;
        result = 1'b0;
        case (op)
            OP_SHR, OP_SHL, OP_ASR: result = 1'b1;
`ifdef USE_ROTATE_EN
            OP_ROR, OP_ROL:         result = 1'b1;
`else
            OP_ROR, OP_ROL:         result = 1'b0;
`endif
            default:                result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/use_if.sv
// Command/data bundle between a host (master) and the universal shift engine (slave).
interface use_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] load_data;
    logic             msb_in;
    logic             lsb_in;
    logic [WIDTH-1:0] out;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_count, load_data, msb_in, lsb_in,
        input  cmd_ready, out, serial_out, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, load_data, msb_in, lsb_in,
        output cmd_ready, out, serial_out, busy, done
    );
endinterface

// File: rtl/use_step.sv
// Combinational single-bit step: next register value and the bit that falls off.
// Rotate paths exist only when USE_ROTATE_EN is defined.
module use_step
    import use_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] cur,
    input  logic             msb_in,
    input  logic             lsb_in,
    output logic [WIDTH-1:0] nxt,
    output logic             exit_bit
);

    always_comb begin
        nxt      = cur;
        exit_bit = 1'b0;
        case (op)
            OP_SHR: begin
                nxt      = {msb_in, cur[WIDTH-1:1]};
                exit_bit = cur[0];
            end
            OP_SHL: begin
                nxt      = {cur[WIDTH-2:0], lsb_in};
                exit_bit = cur[WIDTH-1];
            end
            OP_ASR: begin
                nxt      = {cur[WIDTH-1], cur[WIDTH-1:1]};
                exit_bit = cur[0];
            end
`ifdef USE_ROTATE_EN
            OP_ROR: begin
                nxt      = {cur[0], cur[WIDTH-1:1]};
                exit_bit = cur[0];
            end
            OP_ROL: begin
                nxt      = {cur[WIDTH-2:0], cur[WIDTH-1]};
                exit_bit = cur[WIDTH-1];
            end
`endif
            default: begin
                nxt      = cur;
                exit_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_engine.sv
// Universal shift/rotate register with a valid/ready command port and IDLE/RUN sequencing.
// Define USE_ROTATE_EN to enable ROR/ROL; otherwise they complete as no-ops.
module universal_shift_engine
    import use_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic  CLK,
    input logic  Clear,
    use_if.slave bus
);

    state_e           state;
    op_e              run_op;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] out_q;
    logic             serial_q;
    logic             done_q;
    logic [WIDTH-1:0] step_next;
    logic             step_exit;
    op_e              cmd_op_e;

    assign cmd_op_e = op_e'(bus.cmd_op);

    // The latched op drives the datapath; fill bits come straight from the bus each step.
    use_step #(.WIDTH(WIDTH)) u_step (
        .op       (run_op),
        .cur      (out_q),
        .msb_in   (bus.msb_in),
        .lsb_in   (bus.lsb_in),
        .nxt      (step_next),
        .exit_bit (step_exit)
    );

    always_ff @(posedge CLK) begin
        if (Clear) begin
            state     <= ST_IDLE;
            run_op    <= OP_HOLD;
            remaining <= '0;
            out_q     <= '0;
            serial_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (cmd_op_e == OP_LOAD) begin
                            out_q  <= bus.load_data;
                            done_q <= 1'b1;
                        end else if (is_step_op(cmd_op_e) && (bus.cmd_count != '0)) begin
                            run_op    <= cmd_op_e;
                            remaining <= bus.cmd_count;
                            state     <= ST_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    out_q     <= step_next;
                    serial_q  <= step_exit;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.cmd_ready  = (state == ST_IDLE);
    assign bus.busy       = (state == ST_RUN);
    assign bus.out        = out_q;
    assign bus.serial_out = serial_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_universal_shift_engine.sv
// Directed self-checking bench for universal_shift_engine at WIDTH=8.
// Rotate expectations follow USE_ROTATE_EN.
module tb_universal_shift_engine;
    import use_pkg::*;

    logic CLK = 1'b0;
    logic Clear;
    int   errors = 0;
    int   checks = 0;

    use_if #(.WIDTH(8), .CNT_W(4)) bus ();

    universal_shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK   (CLK),
        .Clear (Clear),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [3:0] cnt,
                                 input logic [7:0] data, input logic msb, input logic lsb);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_count = cnt;
        bus.load_data = data;
        bus.msb_in    = msb;
        bus.lsb_in    = lsb;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        Clear = 1'b1;
        applyStimulus(1'b0, OPC_HOLD, 4'd0, 8'h00, 1'b0, 1'b0);
        @(negedge CLK);
        tick();
        tick();
        checkOutput("reset_out", 32'(bus.out), 32'h00);
        checkOutput("reset_done", 32'(bus.done), 32'h0);
        checkOutput("reset_ready", 32'(bus.cmd_ready), 32'h1);
        checkOutput("reset_busy", 32'(bus.busy), 32'h0);
        checkOutput("reset_serial", 32'(bus.serial_out), 32'h0);

        // LOAD on the first edge after Clear drops
        Clear = 1'b0;
        applyStimulus(1'b1, OPC_LOAD, 4'd0, 8'hA5, 1'b0, 1'b0);
        tick();
        checkOutput("load_out", 32'(bus.out), 32'hA5);
        checkOutput("load_done", 32'(bus.done), 32'h1);
        checkOutput("load_ready", 32'(bus.cmd_ready), 32'h1);
        applyStimulus(1'b0, OPC_HOLD, 4'd0, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("load_done_once", 32'(bus.done), 32'h0);
        checkOutput("load_ready_after", 32'(bus.cmd_ready), 32'h1);

        // SHR N=3 with msb_in=1: A5 -> D2 -> E9 -> F4
        applyStimulus(1'b1, OPC_SHR, 4'd3, 8'h00, 1'b1, 1'b0);
        tick();
        checkOutput("shr_busy0", 32'(bus.busy), 32'h1);
        checkOutput("shr_ready0", 32'(bus.cmd_ready), 32'h0);
        checkOutput("shr_done0", 32'(bus.done), 32'h0);
        applyStimulus(1'b0, OPC_SHR, 4'd3, 8'h00, 1'b1, 1'b0);
        tick();
        checkOutput("shr_step1", 32'(bus.out), 32'hD2);
        checkOutput("shr_busy1", 32'(bus.busy), 32'h1);
        tick();
        checkOutput("shr_busy2", 32'(bus.busy), 32'h1);
        checkOutput("shr_done2", 32'(bus.done), 32'h0);
        tick();
        checkOutput("shr_out", 32'(bus.out), 32'hF4);
        checkOutput("shr_serial", 32'(bus.serial_out), 32'h1);
        checkOutput("shr_done", 32'(bus.done), 32'h1);
        checkOutput("shr_busy_end", 32'(bus.busy), 32'h0);
        checkOutput("shr_ready_end", 32'(bus.cmd_ready), 32'h1);
        tick();
        checkOutput("shr_done_once", 32'(bus.done), 32'h0);

        // ASR N=2 from 81: C0 -> E0, last exiting bit 0
        applyStimulus(1'b1, OPC_LOAD, 4'd0, 8'h81, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, OPC_ASR, 4'd2, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, OPC_HOLD, 4'd0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("asr_out", 32'(bus.out), 32'hE0);
        checkOutput("asr_serial", 32'(bus.serial_out), 32'h0);
        checkOutput("asr_done", 32'(bus.done), 32'h1);

        // SHL N=1 with lsb_in=1: E0 -> C1, msb 1 leaves
        applyStimulus(1'b1, OPC_SHL, 4'd1, 8'h00, 1'b0, 1'b1);
        tick();
        checkOutput("shl_busy", 32'(bus.busy), 32'h1);
        applyStimulus(1'b0, OPC_SHL, 4'd0, 8'h00, 1'b0, 1'b1);
        tick();
        checkOutput("shl_out", 32'(bus.out), 32'hC1);
        checkOutput("shl_serial", 32'(bus.serial_out), 32'h1);
        checkOutput("shl_done", 32'(bus.done), 32'h1);

        // serial_out is left alone by LOAD
        applyStimulus(1'b1, OPC_LOAD, 4'd0, 8'h81, 1'b0, 1'b0);
        tick();
        checkOutput("load_keeps_serial", 32'(bus.serial_out), 32'h1);
        applyStimulus(1'b0, OPC_HOLD, 4'd0, 8'h00, 1'b0, 1'b0);
        tick();

        // ROL N=9 from 81 wraps past a full turn
        applyStimulus(1'b1, OPC_ROL, 4'd9, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, OPC_HOLD, 4'd0, 8'h00, 1'b0, 1'b0);
`ifdef USE_ROTATE_EN
        checkOutput("rol_busy0", 32'(bus.busy), 32'h1);
        repeat (8) tick();
        checkOutput("rol_busy8", 32'(bus.busy), 32'h1);
        checkOutput("rol_done8", 32'(bus.done), 32'h0);
        tick();
        checkOutput("rol_out", 32'(bus.out), 32'h03);
        checkOutput("rol_serial", 32'(bus.serial_out), 32'h1);
        checkOutput("rol_done", 32'(bus.done), 32'h1);
`else
        checkOutput("rol_out", 32'(bus.out), 32'h81);
        checkOutput("rol_done", 32'(bus.done), 32'h1);
        checkOutput("rol_busy", 32'(bus.busy), 32'h0);
`endif
        tick();
        checkOutput("rol_done_once", 32'(bus.done), 32'h0);

        // Clear two steps into SHR N=5, with a LOAD request held high during RUN
        applyStimulus(1'b1, OPC_LOAD, 4'd0, 8'hFF, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, OPC_SHR, 4'd5, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, OPC_LOAD, 4'd0, 8'h55, 1'b0, 1'b0);
        tick();
        checkOutput("abort_step1", 32'(bus.out), 32'h7F);
        checkOutput("abort_ready", 32'(bus.cmd_ready), 32'h0);
        tick();
        checkOutput("abort_step2", 32'(bus.out), 32'h3F);
        checkOutput("abort_busy", 32'(bus.busy), 32'h1);
        Clear = 1'b1;
        applyStimulus(1'b0, OPC_HOLD, 4'd0, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("abort_out", 32'(bus.out), 32'h00);
        checkOutput("abort_busy_clr", 32'(bus.busy), 32'h0);
        checkOutput("abort_done", 32'(bus.done), 32'h0);
        checkOutput("abort_serial", 32'(bus.serial_out), 32'h0);
        Clear = 1'b0;
        tick();
        checkOutput("abort_no_done", 32'(bus.done), 32'h0);
        tick();
        checkOutput("abort_no_done2", 32'(bus.done), 32'h0);
        checkOutput("abort_idle", 32'(bus.cmd_ready), 32'h1);

        // SHL N=0 completes immediately, then LOAD 3C
        applyStimulus(1'b1, OPC_SHL, 4'd0, 8'h00, 1'b0, 1'b1);
        tick();
        checkOutput("zero_done", 32'(bus.done), 32'h1);
        checkOutput("zero_out", 32'(bus.out), 32'h00);
        checkOutput("zero_ready", 32'(bus.cmd_ready), 32'h1);
        applyStimulus(1'b0, OPC_HOLD, 4'd0, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("b2b_gap", 32'(bus.done), 32'h0);
        applyStimulus(1'b1, OPC_LOAD, 4'd0, 8'h3C, 1'b0, 1'b0);
        tick();
        checkOutput("b2b_done", 32'(bus.done), 32'h1);
        checkOutput("b2b_out", 32'(bus.out), 32'h3C);
        applyStimulus(1'b0, OPC_HOLD, 4'd0, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("b2b_done_once", 32'(bus.done), 32'h0);

        // Reserved opcode: no change, single done
        applyStimulus(1'b1, OPC_RSVD, 4'd4, 8'h00, 1'b1, 1'b1);
        tick();
        checkOutput("rsvd_out", 32'(bus.out), 32'h3C);
        checkOutput("rsvd_done", 32'(bus.done), 32'h1);
        checkOutput("rsvd_busy", 32'(bus.busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
